// File: rtl/fp_rf_wr_ctrl.sv
// FP register-file write-port controller: clears every register to zero after reset
// or on request, then shares the single write port round-robin among N_REQ requesters.
module fp_rf_wr_ctrl #(
    parameter int N_REQ        = 2,
    parameter int FREG_NUM     = 32,
    parameter int FREG_IDX_LEN = 5,
    parameter int FLEN         = 64
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  clear_i,
    output logic                                  busy_o,
    input  logic [N_REQ-1:0]                      req_valid_i,
    output logic [N_REQ-1:0]                      req_ready_o,
    input  logic [N_REQ-1:0][FREG_IDX_LEN-1:0]    req_idx_i,
    input  logic [N_REQ-1:0][FLEN-1:0]            req_value_i,
    output logic                                  rf_we_o,
    output logic [FREG_IDX_LEN-1:0]               rf_idx_o,
    output logic [FLEN-1:0]                       rf_value_o,
    output logic                                  dbg_state_o
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [FREG_IDX_LEN-1:0] CNT_LAST = FREG_IDX_LEN'(FREG_NUM - 1);
    localparam logic [PTR_W-1:0]        PTR_LAST = PTR_W'(N_REQ - 1);
    localparam logic [PTR_W:0]          N_REQ_W  = (PTR_W + 1)'(N_REQ);

    typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [FREG_IDX_LEN-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0]        ptr_q, ptr_d;
    logic                    we_d;
    logic [FREG_IDX_LEN-1:0] idx_d;
    logic [FLEN-1:0]         value_d;
    logic                    gnt_found;
    logic [PTR_W-1:0]        gnt_idx;
    logic [PTR_W:0]          cand_sum;
    logic [PTR_W-1:0]        cand;

    assign busy_o      = (state_q == ST_CLEAR);
    assign dbg_state_o = (state_q == ST_RUN);

    // Round-robin scan starting at ptr_q; the first valid requester wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = ptr_q;
        cand_sum  = '0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand_sum = {1'b0, ptr_q} + (PTR_W + 1)'(k);
            if (cand_sum >= N_REQ_W) cand_sum = cand_sum - N_REQ_W;
            cand = cand_sum[PTR_W-1:0];
            if (!gnt_found && req_valid_i[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // Handshake: a write transfers on a rising edge where req_valid_i[i] && req_ready_o[i];
    // ready is a pure function of valid and state, and requesters hold idx/value until ready.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        we_d        = 1'b0;
        idx_d       = rf_idx_o;
        value_d     = rf_value_o;
        req_ready_o = '0;
        unique case (state_q)
            ST_CLEAR: begin
                we_d    = 1'b1;
                idx_d   = cnt_q;
                value_d = '0;
                if (clear_i) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (clear_i) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end else if (gnt_found) begin
                    req_ready_o[gnt_idx] = 1'b1;
                    we_d    = 1'b1;
                    idx_d   = req_idx_i[gnt_idx];
                    value_d = req_value_i[gnt_idx];
                    ptr_d   = (gnt_idx == PTR_LAST) ? '0 : gnt_idx + 1'b1;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_CLEAR;
            cnt_q      <= '0;
            ptr_q      <= '0;
            rf_we_o    <= 1'b0;
            rf_idx_o   <= '0;
            rf_value_o <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            rf_we_o    <= we_d;
            rf_idx_o   <= idx_d;
            rf_value_o <= value_d;
        end
    end
endmodule

// File: doc/fp_rf_wr_ctrl.md
# fp_rf_wr_ctrl

Write-port controller for the floating-point register file. It initialises every FP register to zero after reset or on request, using a clear sequencer that writes one register per cycle. Outside initialisation it shares the register file's single write port among `N_REQ` requesters (commit lane(s), debug/CSR access) with round-robin arbitration. It sits between the commit logic and the FP register file's write port (`comm_valid_i` / `comm_rd_idx_i` / `comm_rd_value_i`) and drives that port from registered outputs.

## Interface
- `N_REQ`, default 2: number of write requesters; must be ≥ 2.
- `FREG_NUM`, default `len5_pkg::FREG_NUM` (32): number of FP registers to clear.
- `FREG_IDX_LEN`, default `len5_pkg::FREG_IDX_LEN` (5): register index width.
- `FLEN`, default `len5_pkg::FLEN` (64): FP data width.

Ports:
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `clear_i` in 1: request a full re-initialisation to zero.
- `busy_o` out 1: high while the clear sequence runs.
- `req_valid_i` in `[N_REQ]`: requester i has a write pending.
- `req_ready_o` out `[N_REQ]`: requester i is granted this cycle.
- `req_idx_i` in `[N_REQ][FREG_IDX_LEN]`: destination register of requester i.
- `req_value_i` in `[N_REQ][FLEN]`: write data of requester i.
- `rf_we_o` out 1: write enable to the register file.
- `rf_idx_o` out `FREG_IDX_LEN`: write index to the register file.
- `rf_value_o` out `FLEN`: write data to the register file.

## Operation
- FSM with two states, CLEAR and RUN, plus a clear counter `cnt` (`FREG_IDX_LEN` bits) and a round-robin pointer `ptr` (0..`N_REQ`-1).
- Reset: state=CLEAR, `cnt`=0, `ptr`=0, `rf_we_o`=0, `rf_idx_o`=0, `rf_value_o`=0.
- `busy_o` = (state==CLEAR), combinational. It reads 1 on the first cycle after reset.
- CLEAR, each cycle:
  - all `req_ready_o`=0;
  - output registers load we=1, idx=`cnt`, value=0;
  - if `cnt`==`FREG_NUM`-1, then `cnt`←0 and state←RUN; otherwise `cnt`←`cnt`+1.
- RUN with `clear_i`=1: no grant, output registers load we=0, state←CLEAR, `cnt`←0. `clear_i` has priority over all requests.
- RUN with `clear_i`=0:
  - g = first i with `req_valid_i`[i]=1, scanning `ptr`, `ptr`+1, … modulo `N_REQ`;
  - `req_ready_o`[g]=1; all other `req_ready_o` are 0;
  - output registers load we=1, idx=`req_idx_i`[g], value=`req_value_i`[g];
  - `ptr`←(g+1) mod `N_REQ`.
- RUN with no valid request: all ready=0, output registers load we=0, `ptr` unchanged.
- `req_ready_o` depends combinationally on `req_valid_i`. Requesters must not make `req_valid_i` depend on `req_ready_o`.
- Requesters hold valid, idx and value stable until they see ready. A transfer occurs on a rising edge where valid && ready.
- `clear_i` during CLEAR restarts the sequence: `cnt`←0, no transition to RUN.
- `rst_i` mid-sequence or mid-RUN returns to the reset state. A request handshaking in the same cycle as `rst_i` is dropped, and `ptr` returns to 0.
- Two requesters targeting the same index are serialized in grant order. The last granted write wins in the register file.

## Timing
- Handshake on edge E: `rf_we_o`/`rf_idx_o`/`rf_value_o` are valid during the cycle after E. The register file updates on edge E+1, and the read ports show the new value from E+1.
- Throughput is one write per cycle; a continuously valid requester receives at least one grant every `N_REQ` cycles.
- Clear sequence: `rf_we_o`=1 with idx 0..`FREG_NUM`-1 on consecutive cycles 2..`FREG_NUM`+1 after reset is released.
- `busy_o` is high for exactly `FREG_NUM` cycles, 1..`FREG_NUM` (the cycles in which `cnt` runs 0..`FREG_NUM`-1). It falls when state→RUN.
- First possible grant is on cycle `FREG_NUM`+1; the last clear write (idx `FREG_NUM`-1) is on `rf_*` during that cycle.
- `clear_i` sampled in RUN: `busy_o` rises the next cycle. No `rf_we_o` from a request appears in the cycle after the `clear_i` edge.

## Test plan
- Reset release, no requests → `busy_o`=1 for 32 cycles; `rf_we_o`=1 with idx 0..31, value 0, on 32 consecutive cycles; then `rf_we_o`=0 and `busy_o`=0.
- After init, req0 valid (idx 3, value 0x3FF0_0000_0000_0000) for 1 cycle → `req_ready_o`=01; next cycle `rf_we_o`=1, `rf_idx_o`=3, `rf_value_o`=0x3FF0…; a register-file read of f3 returns it 2 cycles after the request.
- req0 and req1 both valid for 6 cycles, `ptr`=0 → grants alternate 0,1,0,1,0,1; `rf_idx_o` follows each requester's idx one cycle later.
- Requests held valid during the clear sequence (`busy_o`=1) → `req_ready_o`=0 throughout; first grant to req0 (`ptr`=0) in the cycle after `busy_o` falls.
- `clear_i` pulsed in RUN while req1 is valid → no grant that cycle; `busy_o` rises next cycle; 32 zero writes follow. Second `clear_i` at `cnt`=10 → sequence restarts at idx 0.
- `rst_i` asserted at `cnt`=20 → next cycle `rf_we_o`=0, outputs 0. After release, the sequence restarts from idx 0 and `ptr`=0.
